// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - FIFO read-side drainer framing words into bursts; FIFO_RD_FLUSH_EN adds idle flush of partial bursts
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         ENABLE,
    input  logic [DATA_WIDTH-1:0]        FIFO_Q,
    input  logic                         FIFO_EMPTY,
    output logic                         FIFO_DEQ,
    output logic [DATA_WIDTH-1:0]        OUT_DATA,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic                         OUT_LAST,
    output logic [$clog2(BURST_LEN)-1:0] BEAT,
    output logic                         BUSY
);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

    logic [DATA_WIDTH-1:0] mem [4];
    logic [1:0]            rd_ptr;
    logic [1:0]            wr_ptr;
    logic [2:0]            occ;
    logic                  inflight;
    logic [BEAT_W-1:0]     beat;
    logic                  handshake;
    logic                  at_end;

    // Counting the in-flight word guarantees the 4-entry buffer can never overflow.
    assign FIFO_DEQ  = RST_N & ENABLE & ~FIFO_EMPTY & ((occ + {2'b00, inflight}) <= 3'd3);
    assign handshake = OUT_VALID & OUT_READY;
    assign at_end    = (beat == BEAT_MAX);
    assign OUT_DATA  = mem[rd_ptr];
    assign BEAT      = beat;
    assign BUSY      = (occ != 3'd0) | inflight;

`ifdef FIFO_RD_FLUSH_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    logic [IDLE_W-1:0] idle;
    logic              shown;
    logic              shown_last;
    logic              timed_out;

    assign timed_out = (idle == IDLE_MAX);
    // A lone head is held back until a successor exists, the burst ends, or the idle timer expires.
    assign OUT_VALID = (occ != 3'd0) &
                       (shown | (occ >= 3'd2) | inflight | at_end | timed_out);
    assign OUT_LAST  = OUT_VALID & (shown ? shown_last : (at_end | timed_out));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            idle       <= '0;
            shown      <= 1'b0;
            shown_last <= 1'b0;
        end else begin
            shown      <= OUT_VALID & ~OUT_READY;
            shown_last <= OUT_LAST;
            if (inflight | handshake) begin
                idle <= '0;
            end else if ((occ == 3'd1) & ~OUT_VALID & ~timed_out) begin
                idle <= idle + 1'b1;
            end
        end
    end
`else
    assign OUT_VALID = (occ != 3'd0);
    assign OUT_LAST  = OUT_VALID & at_end;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            occ      <= 3'd0;
            inflight <= 1'b0;
            beat     <= '0;
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else begin
            inflight <= FIFO_DEQ;
            if (inflight) begin
                mem[wr_ptr] <= FIFO_Q;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (handshake) begin
                rd_ptr <= rd_ptr + 2'd1;
                beat   <= OUT_LAST ? '0 : beat + 1'b1;
            end
            occ <= occ + {2'b00, inflight} - {2'b00, handshake};
        end
    end
endmodule
